// File: rtl/dmem_responder.sv
// Data-side req/gnt/valid responder backed by a word-addressed SRAM array.
// Configurable grant wait states and fixed-latency, never-stalled response pipeline.
module dmem_responder #(
  parameter int unsigned DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned GNT_WAIT    = 0,
  parameter int unsigned RSP_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic        data_gnt,
  output logic [31:0] data_rdata,
  output logic        data_valid,
  output logic        data_error
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] Span = 33'(DEPTH) << 2;
  localparam int          Last = int'(RSP_LATENCY) - 1;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        gnt;

  logic [31:0]   offset;
  logic          in_range;
  logic          addr_err;
  logic [IdxW-1:0] idx;
  logic [31:0]   rd_word;

  logic [31:0] mem [DEPTH];

  logic        stg_valid_q  [RSP_LATENCY];
  logic        stg_err_q    [RSP_LATENCY];
  logic [31:0] stg_rdata_q  [RSP_LATENCY];
  logic        stg_in_valid [RSP_LATENCY];
  logic        stg_in_err   [RSP_LATENCY];
  logic [31:0] stg_in_rdata [RSP_LATENCY];

  // Grant FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (data_req) begin
          if (GNT_WAIT == 0) begin
            gnt = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 3'd1;
          end
        end
      end
      StWait: begin
        if (!data_req) begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end else if (cnt_q == 3'(GNT_WAIT)) begin
          gnt     = 1'b1;
          state_d = StIdle;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // No grant is issued on a reset edge, so nothing is written or queued then.
  assign data_gnt = gnt & reset_n;

  // Address decode
  assign offset   = data_addr - BASE_ADDR;
  assign in_range = (data_addr >= BASE_ADDR) && ({1'b0, offset} < Span);
  assign addr_err = (data_addr[1:0] != 2'b00) || !in_range;
  assign idx      = offset[IdxW+1:2];

  // Array: byte-enabled write at the grant edge, full-word read for loads.
  always_ff @(posedge clk) begin
    if (data_gnt && data_wr && !addr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be[b]) begin
          mem[idx][8*b +: 8] <= data_wdata[8*b +: 8];
        end
      end
    end
  end

  assign rd_word = (data_wr || addr_err) ? 32'h0 : mem[idx];

  // Response pipeline
  always_comb begin
    stg_in_valid[0] = data_gnt;
    stg_in_err[0]   = addr_err;
    stg_in_rdata[0] = rd_word;
    for (int i = 1; i < int'(RSP_LATENCY); i++) begin
      stg_in_valid[i] = stg_valid_q[i-1];
      stg_in_err[i]   = stg_err_q[i-1];
      stg_in_rdata[i] = stg_rdata_q[i-1];
    end
  end

  // The output stage only updates its payload on a valid, so it holds between responses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(RSP_LATENCY); i++) begin
        stg_valid_q[i] <= 1'b0;
        stg_err_q[i]   <= 1'b0;
        stg_rdata_q[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < int'(RSP_LATENCY); i++) begin
        stg_valid_q[i] <= stg_in_valid[i];
        if (stg_in_valid[i] || (i != Last)) begin
          stg_err_q[i]   <= stg_in_err[i];
          stg_rdata_q[i] <= stg_in_rdata[i];
        end
      end
    end
  end

  assign data_valid = stg_valid_q[Last];
  assign data_error = stg_err_q[Last];
  assign data_rdata = stg_rdata_q[Last];

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: five parameter corners run in turn, directed
// vectors with hand-computed responses followed by random traffic against a memory model.
module tb_dmem_responder;

  localparam int NCFG = 5;

  function automatic int unsigned cfg_gw(int i);
    case (i)
      0: return 0;
      1: return 3;
      2: return 0;
      3: return 1;
      default: return 7;
    endcase
  endfunction

  function automatic int unsigned cfg_lat(int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 4;
      3: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int unsigned cfg_depth(int i);
    case (i)
      3: return 32;
      4: return 16;
      default: return 64;
    endcase
  endfunction

  function automatic logic [31:0] cfg_base(int i);
    case (i)
      1: return 32'h0000_1000;
      3: return 32'h8000_0000;
      4: return 32'h0000_0100;
      default: return 32'h0000_0000;
    endcase
  endfunction

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic        req_a   [NCFG];
  logic        gnt_a   [NCFG];
  logic [31:0] rdata_a [NCFG];
  logic        valid_a [NCFG];
  logic        err_a   [NCFG];

  exp_t        sb[$];
  int          cyc = 0;
  int          cur;
  bit          done;
  logic [31:0] mem_m [64];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_rst = 1'b0;
  bit pend = 1'b0;
  int start_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    dmem_responder #(
      .DEPTH      (cfg_depth(g)),
      .BASE_ADDR  (cfg_base(g)),
      .GNT_WAIT   (cfg_gw(g)),
      .RSP_LATENCY(cfg_lat(g))
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .data_req  (req_a[g]),
      .data_wr   (data_wr),
      .data_addr (data_addr),
      .data_wdata(data_wdata),
      .data_be   (data_be),
      .data_gnt  (gnt_a[g]),
      .data_rdata(rdata_a[g]),
      .data_valid(valid_a[g]),
      .data_error(err_a[g])
    );
  end

  // Monitor: reset state, grant timing, response scoreboard, termination.
  always @(negedge clk) begin
    int w;
    exp_t e;
    if (chk_rst) begin
      for (int i = 0; i < NCFG; i++) begin
        n_cmp++;
        if (valid_a[i] !== 1'b0 || err_a[i] !== 1'b0 || rdata_a[i] !== 32'h0) begin
          n_bad++;
          $display("FAIL reset_state inst=%0d valid=%b err=%b rdata=%h, want 0 0 00000000",
                   i, valid_a[i], err_a[i], rdata_a[i]);
        end
      end
    end
    chk_rst = !reset_n;

    for (int i = 0; i < NCFG; i++) begin
      if (req_a[i] !== 1'b1) begin
        n_cmp++;
        if (gnt_a[i] !== 1'b0) begin
          n_bad++;
          $display("FAIL gnt_without_req inst=%0d cyc=%0d gnt=%b, want 0", i, cyc, gnt_a[i]);
        end
      end
    end

    if (reset_n && req_a[cur] === 1'b1) begin
      if (!pend) begin
        pend = 1'b1;
        start_cyc = cyc;
      end
      w = cyc - start_cyc;
      if (gnt_a[cur] === 1'b1 || w == int'(cfg_gw(cur))) begin
        n_cmp++;
        if (!(gnt_a[cur] === 1'b1 && w == int'(cfg_gw(cur)))) begin
          n_bad++;
          $display("FAIL gnt_timing inst=%0d cyc=%0d gnt=%b wait=%0d, want gnt=1 at wait=%0d",
                   cur, cyc, gnt_a[cur], w, cfg_gw(cur));
        end
        if (gnt_a[cur] === 1'b1) pend = 1'b0;
      end
    end else begin
      pend = 1'b0;
    end

    for (int i = 0; i < NCFG; i++) begin
      if (valid_a[i] === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_valid inst=%0d cyc=%0d rdata=%h err=%b, want no response",
                   i, cyc, rdata_a[i], err_a[i]);
        end else begin
          e = sb.pop_front();
          if (e.inst != i || rdata_a[i] !== e.rdata || err_a[i] !== e.err || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL response inst=%0d cyc=%0d rdata=%h err=%b, want inst=%0d cyc=%0d rdata=%h err=%b",
                     i, cyc, rdata_a[i], err_a[i], e.inst, e.cyc, e.rdata, e.err);
          end
        end
      end
    end

    if (done || cyc > 95000) begin
      n_cmp++;
      if (!done) begin
        n_bad++;
        $display("FAIL run_timeout cyc=%0d, want completion before 95000", cyc);
      end else if (sb.size() != 0) begin
        n_bad++;
        $display("FAIL missing_responses outstanding=%0d, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one request, holds it until granted (bounded) and queues the expected response.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rd, input bit exp_err);
    bit   granted = 1'b0;
    exp_t e;
    data_wr    = wr;
    data_addr  = addr;
    data_wdata = wdata;
    data_be    = be;
    req_a[cur] = 1'b1;
    for (int k = 0; k < 16 && !granted; k++) begin
      @(negedge clk);
      if (gnt_a[cur] === 1'b1) begin
        granted = 1'b1;
        e.inst  = cur;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.cyc   = cyc + int'(cfg_lat(cur));
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    req_a[cur] = 1'b0;
  endtask

  function automatic bit is_err(input logic [31:0] addr);
    longint a = {32'h0, addr};
    longint b = {32'h0, cfg_base(cur)};
    longint span = 4 * longint'(cfg_depth(cur));
    return (addr[1:0] != 2'b00) || (a < b) || (a >= b + span);
  endfunction

  task automatic model_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be);
    bit          err = is_err(addr);
    int          idx = int'((addr - cfg_base(cur)) >> 2);
    logic [31:0] exp_rd = 32'h0;
    if (!wr && !err) exp_rd = mem_m[idx];
    issue(wr, addr, wdata, be, exp_rd, err);
    if (wr && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  endtask

  task automatic run_cfg();
    logic [31:0] b    = cfg_base(cur);
    logic [31:0] last = cfg_base(cur) + 4 * cfg_depth(cur) - 4;
    logic [31:0] oor  = cfg_base(cur) + 4 * cfg_depth(cur);
    logic [31:0] a;
    int          d    = int'(cfg_depth(cur));

    issue(1'b1, b + 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    issue(1'b0, b + 32'h10, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0);
    issue(1'b1, b + 32'h20, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    issue(1'b1, b + 32'h20, 32'h0000_00AA, 4'h1, 32'h0, 1'b0);
    issue(1'b1, b + 32'h20, 32'h5500_0000, 4'h8, 32'h0, 1'b0);
    issue(1'b0, b + 32'h20, 32'h0,         4'h0, 32'h5522_33AA, 1'b0);
    issue(1'b0, b + 32'h22, 32'h0,         4'hF, 32'h0, 1'b1);
    issue(1'b1, last,       32'h0BAD_F00D, 4'hF, 32'h0, 1'b0);
    issue(1'b1, oor,        32'hCAFE_F00D, 4'hF, 32'h0, 1'b1);
    issue(1'b0, last,       32'h0,         4'hF, 32'h0BAD_F00D, 1'b0);
    issue(1'b1, b + 32'h10, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
    issue(1'b0, b + 32'h10, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0);
    // Four requests held back-to-back.
    issue(1'b0, b + 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, b + 32'h20, 32'h0, 4'hF, 32'h5522_33AA, 1'b0);
    issue(1'b0, last,       32'h0, 4'hF, 32'h0BAD_F00D, 1'b0);
    issue(1'b0, b + 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
    idle(int'(cfg_lat(cur)) + 1);

    if (cfg_gw(cur) >= 3) begin
      data_wr    = 1'b0;
      data_addr  = b + 32'h10;
      req_a[cur] = 1'b1;
      idle(2);
      req_a[cur] = 1'b0;
      idle(int'(cfg_gw(cur)) + 2);
    end

    // Reset with loads in flight; the array must survive it.
    issue(1'b0, b + 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, b + 32'h20, 32'h0, 4'hF, 32'h5522_33AA, 1'b0);
    issue(1'b0, last,       32'h0, 4'hF, 32'h0BAD_F00D, 1'b0);
    idle(2);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    reset_n = 1'b1;
    issue(1'b0, b + 32'h20, 32'h0, 4'hF, 32'h5522_33AA, 1'b0);
    idle(int'(cfg_lat(cur)) + 1);

    for (int i = 0; i < d; i++) model_req(1'b1, b + 4 * i, $urandom, 4'hF);
    for (int n = 0; n < 2000; n++) begin
      a = b + 4 * $urandom_range(0, d - 1);
      if ($urandom_range(0, 99) < 5) begin
        case ($urandom_range(0, 2))
          0: a = a | 32'($urandom_range(1, 3));
          1: a = oor + 4 * $urandom_range(0, 15);
          default: a = b - 4 * $urandom_range(1, 4);
        endcase
      end
      model_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 9) >= 7) idle($urandom_range(1, 3));
    end
    idle(int'(cfg_lat(cur)) + 2);
  endtask

  initial begin
    reset_n    = 1'b0;
    data_wr    = 1'b0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    data_be    = 4'h0;
    cur        = 0;
    done       = 1'b0;
    for (int i = 0; i < NCFG; i++) req_a[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    for (int c = 0; c < NCFG; c++) begin
      cur = c;
      run_cfg();
    end
    idle(6);
    done = 1'b1;
  end

endmodule
